// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// FSM states and the architectural PC register index.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_t;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] PC_REG = 4'd15;

endpackage

// File: rtl/fwd_select.sv
// Priority comparator for one ID source field: youngest producer (EX) wins,
// then MEM, then WB; the PC and unused fields always read the register file.
module fwd_select
    import pipe_pkg::*;
(
    input  logic [3:0] field,
    input  logic       used,
    input  logic [3:0] ex_rd,
    input  logic       ex_en,
    input  logic [3:0] mem_rd,
    input  logic       mem_en,
    input  logic [3:0] wb_rd,
    input  logic       wb_en,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (used && field != PC_REG) begin
            if (ex_en && ex_rd == field)
                sel = FWD_EX;
            else if (mem_en && mem_rd == field)
                sel = FWD_MEM;
            else if (wb_en && wb_rd == field)
                sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: memory-stall FSM, load-use bubble insertion,
// branch flush of IF_ID, operand forwarding selects and stall statistics.
module hazard_controller
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             R,
    input  logic [3:0]       id_rn,
    input  logic [3:0]       id_rm,
    input  logic [3:0]       id_rd,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_use_rd,
    input  logic [3:0]       ex_rd,
    input  logic             ex_rf_enable,
    input  logic             ex_load_instr,
    input  logic [3:0]       mem_rd,
    input  logic             mem_rf_enable,
    input  logic [3:0]       wb_rd,
    input  logic             wb_rf_enable,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             pc_le,
    output logic             ifid_le,
    output logic             ifid_flush,
    output logic             cu_nop,
    output logic             pipe_hold,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       fwd_d,
    output logic [CNT_W-1:0] stall_count,
    output logic             mem_error
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              stall_mem;
    logic              load_use;

    logic [3:0] field [3];
    logic       used  [3];
    logic [1:0] sel   [3];

    assign field = '{id_rn, id_rm, id_rd};
    assign used  = '{id_use_rn, id_use_rm, id_use_rd};

    // A ready memory releases the pipe in the same cycle, in either state.
    assign stall_mem = !mem_ready && (mem_req || state == ST_MEM_WAIT);

    assign load_use = ex_load_instr && ex_rf_enable &&
                      ((id_use_rn && ex_rd == id_rn) ||
                       (id_use_rm && ex_rd == id_rm) ||
                       (id_use_rd && ex_rd == id_rd));

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_fwd
            fwd_select u_fwd (
                .field  (field[gi]),
                .used   (used[gi]),
                .ex_rd  (ex_rd),
                .ex_en  (ex_rf_enable),
                .mem_rd (mem_rd),
                .mem_en (mem_rf_enable),
                .wb_rd  (wb_rd),
                .wb_en  (wb_rf_enable),
                .sel    (sel[gi])
            );
        end
    endgenerate

    assign fwd_a = R ? FWD_RF : sel[0];
    assign fwd_b = R ? FWD_RF : sel[1];
    assign fwd_d = R ? FWD_RF : sel[2];

    always_comb begin
        pc_le      = 1'b1;
        ifid_le    = 1'b1;
        ifid_flush = 1'b0;
        cu_nop     = 1'b0;
        pipe_hold  = 1'b0;
        if (R) begin
            pc_le   = 1'b0;
            ifid_le = 1'b0;
            cu_nop  = 1'b1;
        end else if (stall_mem) begin
            pc_le     = 1'b0;
            ifid_le   = 1'b0;
            pipe_hold = 1'b1;
        end else if (load_use) begin
            pc_le   = 1'b0;
            ifid_le = 1'b0;
            cu_nop  = 1'b1;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            stall_count <= '0;
            mem_error   <= 1'b0;
        end else begin
            if (!pc_le && stall_count != '1)
                stall_count <= stall_count + 1'b1;

            if (state == ST_RUN) begin
                if (mem_req && !mem_ready) begin
                    state    <= ST_MEM_WAIT;
                    wait_cnt <= '0;
                end
            end else begin
                if (mem_ready) begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    // Give up on the access: flag it and let the pipe run.
                    mem_error <= 1'b1;
                    state     <= ST_RUN;
                    wait_cnt  <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_hazard_controller;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 16;

    logic             clk = 1'b0;
    logic             R   = 1'b1;
    logic [3:0]       id_rn, id_rm, id_rd;
    logic             id_use_rn, id_use_rm, id_use_rd;
    logic [3:0]       ex_rd, mem_rd, wb_rd;
    logic             ex_rf_enable, ex_load_instr, mem_rf_enable, wb_rf_enable;
    logic             mem_req, mem_ready, branch_taken;
    logic             pc_le, ifid_le, ifid_flush, cu_nop, pipe_hold;
    logic [1:0]       fwd_a, fwd_b, fwd_d;
    logic [CNT_W-1:0] stall_count;
    logic             mem_error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state
    bit m_waiting;
    int m_wait_cycles;
    int m_stalls;
    bit m_err;

    always #5 clk = ~clk;

    hazard_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .R(R),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
        .ex_rd(ex_rd), .ex_rf_enable(ex_rf_enable), .ex_load_instr(ex_load_instr),
        .mem_rd(mem_rd), .mem_rf_enable(mem_rf_enable),
        .wb_rd(wb_rd), .wb_rf_enable(wb_rf_enable),
        .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .pc_le(pc_le), .ifid_le(ifid_le), .ifid_flush(ifid_flush),
        .cu_nop(cu_nop), .pipe_hold(pipe_hold),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_d(fwd_d),
        .stall_count(stall_count), .mem_error(mem_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Which pipeline stage should feed a field: newest writer wins.
    function automatic int model_fwd(input bit use_f, input int f);
        if (!use_f || f == 15) return 0;
        if (ex_rf_enable  && int'(ex_rd)  == f) return 1;
        if (mem_rf_enable && int'(mem_rd) == f) return 2;
        if (wb_rf_enable  && int'(wb_rd)  == f) return 3;
        return 0;
    endfunction

    task automatic set_idle();
        id_rn = 4'd0; id_rm = 4'd0; id_rd = 4'd0;
        id_use_rn = 1'b0; id_use_rm = 1'b0; id_use_rd = 1'b0;
        ex_rd = 4'd0; mem_rd = 4'd0; wb_rd = 4'd0;
        ex_rf_enable = 1'b0; ex_load_instr = 1'b0;
        mem_rf_enable = 1'b0; wb_rf_enable = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1; branch_taken = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_pc_le", pc_le, 0);
        check("rst_ifid_le", ifid_le, 0);
        check("rst_flush", ifid_flush, 0);
        check("rst_cu_nop", cu_nop, 1);
        check("rst_hold", pipe_hold, 0);
        check("rst_fwd", {fwd_a, fwd_b, fwd_d}, 0);
        check("rst_stall_count", stall_count, 0);
        check("rst_mem_error", mem_error, 0);
    endtask

    // Asserts R asynchronously between edges, then releases it after an edge.
    task automatic do_reset();
        R = 1'b1;
        #1;
        check_reset_outputs();
        m_waiting = 0; m_wait_cycles = 0; m_stalls = 0; m_err = 0;
        @(posedge clk); #1;
        R = 1'b0;
    endtask

    // One clock cycle with the currently applied inputs: check the
    // combinational outputs, advance the model, then check registered state.
    task automatic step();
        bit stall, lu, br, adv;
        #1;
        stall = !mem_ready && (m_waiting || mem_req);
        lu = !stall && ex_load_instr && ex_rf_enable &&
             ((id_use_rn && ex_rd == id_rn) || (id_use_rm && ex_rd == id_rm) ||
              (id_use_rd && ex_rd == id_rd));
        br  = !stall && !lu && branch_taken;
        adv = !(stall || lu);
        check("pc_le", pc_le, adv);
        check("ifid_le", ifid_le, adv);
        check("ifid_flush", ifid_flush, br);
        check("cu_nop", cu_nop, lu);
        check("pipe_hold", pipe_hold, stall);
        check("fwd_a", fwd_a, model_fwd(id_use_rn, id_rn));
        check("fwd_b", fwd_b, model_fwd(id_use_rm, id_rm));
        check("fwd_d", fwd_d, model_fwd(id_use_rd, id_rd));
        $display("cyc %0d req=%0b rdy=%0b br=%0b pc_le=%0b nop=%0b hold=%0b flush=%0b fwd=%0d/%0d/%0d",
                 cyc, mem_req, mem_ready, branch_taken, pc_le, cu_nop, pipe_hold,
                 ifid_flush, fwd_a, fwd_b, fwd_d);

        if (!adv && m_stalls < (1 << CNT_W) - 1) m_stalls++;
        if (m_waiting) begin
            if (mem_ready) begin
                m_waiting = 0;
            end else begin
                m_wait_cycles++;
                if (m_wait_cycles == MEM_TIMEOUT) begin
                    m_err = 1;
                    m_waiting = 0;
                end
            end
        end else if (mem_req && !mem_ready) begin
            m_waiting = 1;
            m_wait_cycles = 0;
        end

        @(posedge clk); #1;
        cyc++;
        check("stall_count", stall_count, m_stalls);
        check("mem_error", mem_error, m_err);
    endtask

    function automatic logic [3:0] rand_reg();
        int r;
        r = $urandom_range(0, 9);
        return (r > 7) ? 4'd15 : 4'(r);
    endfunction

    initial begin
        set_idle();
        #2;
        check_reset_outputs();
        do_reset();

        // load-use on Rn, then the load sits in MEM and is forwarded
        ex_load_instr = 1; ex_rf_enable = 1; ex_rd = 4'd3;
        id_rn = 4'd3; id_use_rn = 1;
        step();
        ex_load_instr = 0; ex_rf_enable = 0;
        mem_rd = 4'd3; mem_rf_enable = 1;
        #1;
        check("lu_fwd_a_mem", fwd_a, 2);
        step();
        check("lu_stall_count", stall_count, 1);

        // forwarding priority and the PC exception
        set_idle();
        ex_rd = 4'd5; mem_rd = 4'd5; wb_rd = 4'd5;
        ex_rf_enable = 1; mem_rf_enable = 1; wb_rf_enable = 1;
        id_rm = 4'd5; id_use_rm = 1;
        #1; check("fwd_b_ex", fwd_b, 1);
        step();
        ex_rf_enable = 0;
        #1; check("fwd_b_mem", fwd_b, 2);
        step();
        id_rm = 4'd15;
        #1; check("fwd_b_pc", fwd_b, 0);
        step();

        // three-cycle memory stall then completion
        set_idle();
        do_reset();
        mem_req = 1; mem_ready = 0;
        repeat (3) step();
        mem_ready = 1;
        step();
        check("mem_stall_count", stall_count, 3);

        // timeout: entry cycle plus MEM_TIMEOUT wait cycles
        do_reset();
        mem_req = 1; mem_ready = 0;
        repeat (MEM_TIMEOUT) step();
        check("timeout_not_yet", mem_error, 0);
        step();
        check("timeout_err", mem_error, 1);
        mem_req = 0;
        repeat (4) step();
        check("timeout_sticky", mem_error, 1);

        // branch coincident with load-use: bubble first, flush next cycle
        set_idle();
        ex_load_instr = 1; ex_rf_enable = 1; ex_rd = 4'd7;
        id_rm = 4'd7; id_use_rm = 1; branch_taken = 1;
        step();
        ex_load_instr = 0; ex_rf_enable = 0;
        #1;
        check("br_after_lu_flush", ifid_flush, 1);
        check("br_after_lu_pc_le", pc_le, 1);
        step();

        // reset pulse in the middle of a memory wait
        set_idle();
        mem_req = 1; mem_ready = 0;
        repeat (2) step();
        do_reset();
        mem_req = 0; mem_ready = 1;
        step();
        check("post_reset_run", pc_le, 1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            id_rn = rand_reg(); id_rm = rand_reg(); id_rd = rand_reg();
            id_use_rn = 1'($urandom); id_use_rm = 1'($urandom); id_use_rd = 1'($urandom);
            ex_rd = rand_reg(); mem_rd = rand_reg(); wb_rd = rand_reg();
            ex_rf_enable = 1'($urandom); ex_load_instr = ($urandom_range(0, 2) == 0);
            mem_rf_enable = 1'($urandom); wb_rf_enable = 1'($urandom);
            mem_req = ($urandom_range(0, 2) == 0);
            mem_ready = ($urandom_range(0, 2) != 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
